// File: rtl/ascon_perm_engine.sv
// Ascon-p permutation engine with a persistent 320-bit state. It runs queued commands made of
// an optional word load (overwrite or XOR), a variable round count and an optional word unload.
module ascon_perm_engine #(
    parameter int CCW  = 32,
    parameter int UROL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [3:0]     cmd_rounds,
    input  logic [1:0]     cmd_load,
    input  logic           cmd_unload,
    input  logic [CCW-1:0] din,
    input  logic           din_valid,
    output logic           din_ready,
    output logic [CCW-1:0] dout,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic           dout_last,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int NW  = 320 / CCW;
    localparam int WCW = $clog2(NW);
    localparam logic [WCW-1:0] WC_LAST = WCW'(NW - 1);
    localparam logic [3:0] UROL4 = 4'(UROL);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_PERM   = 2'd2;
    localparam logic [1:0] S_UNLOAD = 2'd3;

    logic [1:0]     fsm_reg;
    logic [3:0]     rounds_reg;
    logic [1:0]     load_reg;
    logic           unload_reg;
    logic [3:0]     rc_reg;
    logic [WCW-1:0] wc_reg;
    logic           done_reg;
    logic           err_reg;
    logic [CCW-1:0] state_reg [NW];

    logic [319:0]   state_flat;
    logic [319:0]   stage [UROL+1];
    logic [319:0]   perm_out;
    logic [3:0]     rc_after;
    logic           cmd_bad;
    logic [1:0]     cmd_next;
    logic [1:0]     load_next;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[63:0];
        x1 = s[127:64];
        x2 = s[191:128];
        x3 = s[255:192];
        x4 = s[319:256];
        x2[7:0] = x2[7:0] ^ {4'd15 - idx, idx};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1) ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7) ^ ror64(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    // First phase after the load phase (or after acceptance when nothing is loaded).
    function automatic logic [1:0] after_load(input logic [3:0] rounds, input logic unload);
        if (rounds != 4'd0)
            return S_PERM;
        else if (unload)
            return S_UNLOAD;
        else
            return S_IDLE;
    endfunction

    // Word k sits at bits [CCW*k +: CCW] of the lane-packed state, which matches the lane/half map.
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_flat
            assign state_flat[CCW*gi +: CCW] = state_reg[gi];
        end
    endgenerate

    assign stage[0] = state_flat;
    generate
        for (genvar gi = 0; gi < UROL; gi++) begin : g_round
            assign stage[gi+1] = ascon_round(stage[gi], rc_reg + 4'(gi));
        end
    endgenerate
    assign perm_out = stage[UROL];

    assign rc_after  = rc_reg + UROL4;
    assign cmd_bad   = (cmd_rounds > 4'd12) || ((cmd_rounds % UROL4) != 4'd0) || (cmd_load == 2'd3);
    assign cmd_next  = after_load(cmd_rounds, cmd_unload);
    assign load_next = after_load(rounds_reg, unload_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg    <= S_IDLE;
            rounds_reg <= '0;
            load_reg   <= '0;
            unload_reg <= 1'b0;
            rc_reg     <= '0;
            wc_reg     <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            for (int i = 0; i < NW; i++)
                state_reg[i] <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (fsm_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_bad) begin
                            err_reg <= 1'b1;
                        end else begin
                            rounds_reg <= cmd_rounds;
                            load_reg   <= cmd_load;
                            unload_reg <= cmd_unload;
                            rc_reg     <= 4'd12 - cmd_rounds;
                            if (cmd_load != 2'd0) begin
                                fsm_reg <= S_LOAD;
                            end else begin
                                fsm_reg  <= cmd_next;
                                done_reg <= (cmd_next == S_IDLE);
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (din_valid) begin
                        state_reg[wc_reg] <= (load_reg == 2'd2) ? (state_reg[wc_reg] ^ din) : din;
                        if (wc_reg == WC_LAST) begin
                            wc_reg   <= '0;
                            fsm_reg  <= load_next;
                            done_reg <= (load_next == S_IDLE);
                        end else begin
                            wc_reg <= wc_reg + WCW'(1);
                        end
                    end
                end
                S_PERM: begin
                    for (int i = 0; i < NW; i++)
                        state_reg[i] <= perm_out[CCW*i +: CCW];
                    rc_reg <= rc_after;
                    if (rc_after == 4'd12) begin
                        fsm_reg  <= unload_reg ? S_UNLOAD : S_IDLE;
                        done_reg <= !unload_reg;
                    end
                end
                S_UNLOAD: begin
                    if (dout_ready) begin
                        if (wc_reg == WC_LAST) begin
                            wc_reg   <= '0;
                            fsm_reg  <= S_IDLE;
                            done_reg <= 1'b1;
                        end else begin
                            wc_reg <= wc_reg + WCW'(1);
                        end
                    end
                end
                default: fsm_reg <= S_IDLE;
            endcase
        end
    end

    // cmd_ready is gated by rst so it drops the moment reset is asserted.
    assign cmd_ready  = (fsm_reg == S_IDLE) && !rst;
    assign din_ready  = (fsm_reg == S_LOAD);
    assign dout_valid = (fsm_reg == S_UNLOAD);
    assign dout       = dout_valid ? state_reg[wc_reg] : '0;
    assign dout_last  = dout_valid && (wc_reg == WC_LAST);
    assign busy       = (fsm_reg != S_IDLE);
    assign done       = done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Bench for ascon_perm_engine: a CCW=32/UROL=2 instance and a CCW=64/UROL=4 instance,
// with per-instance scoreboards of expected unload words and a bit-column reference model.
module tb_ascon_perm_engine;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_unload, din_valid, din_ready;
    logic [3:0]  cmd_rounds;
    logic [1:0]  cmd_load;
    logic [31:0] din, dout;
    logic        dout_valid, dout_ready, dout_last, busy, done, err;

    logic        b_cmd_valid, b_cmd_ready, b_din_valid, b_din_ready;
    logic [63:0] b_din, b_dout;
    logic        b_dout_valid, b_dout_last, b_busy, b_done, b_err;

    ascon_perm_engine #(.CCW(32), .UROL(2)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rounds(cmd_rounds), .cmd_load(cmd_load), .cmd_unload(cmd_unload),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
        .busy(busy), .done(done), .err(err)
    );

    ascon_perm_engine #(.CCW(64), .UROL(4)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_rounds(cmd_rounds), .cmd_load(cmd_load), .cmd_unload(cmd_unload),
        .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
        .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(dout_ready), .dout_last(b_dout_last),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    localparam logic [63:0] IV = 64'h00400c0000000100;
    localparam logic [63:0] KAT [5] = '{64'hee9398aadb67f03d, 64'h8bb21831c60f1002,
                                        64'hb48a92db98d5da62, 64'h43189921b8f8e3e8,
                                        64'h348fa5c9d525e140};
    localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                         5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                         5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                         5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    int          checks = 0;
    int          errors = 0;
    logic [31:0] qa [$];
    logic [63:0] qb [$];
    int          beat_a = 0;
    int          beat_b = 0;
    logic [63:0] m [5];
    logic [31:0] ldw [10];
    logic [63:0] ldw64 [5];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            beat_a <= 0;
        end else if (dout_valid) begin
            if (qa.size() == 0) begin
                check("a_unexpected_dout", 64'(dout_valid), 64'(0));
            end else begin
                check("a_dout", 64'(dout), 64'(qa[0]));
                check("a_dout_last", 64'(dout_last), 64'(beat_a == 9));
                if (dout_ready) begin
                    void'(qa.pop_front());
                    beat_a <= (beat_a == 9) ? 0 : beat_a + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            beat_b <= 0;
        end else if (b_dout_valid) begin
            if (qb.size() == 0) begin
                check("b_unexpected_dout", 64'(b_dout_valid), 64'(0));
            end else begin
                check("b_dout", b_dout, qb[0]);
                check("b_dout_last", 64'(b_dout_last), 64'(beat_b == 4));
                if (dout_ready) begin
                    void'(qb.pop_front());
                    beat_b <= (beat_b == 4) ? 0 : beat_b + 1;
                end
            end
        end
    end

    function automatic logic [63:0] rr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference permutation: S-box applied as a 5-bit table per bit column.
    task automatic model_perm(input int rounds);
        logic [63:0] s [5];
        logic [4:0]  v, o;
        for (int r = 12 - rounds; r < 12; r++) begin
            m[2][7:0] = m[2][7:0] ^ {4'(15 - r), 4'(r)};
            for (int b = 0; b < 64; b++) begin
                v = {m[0][b], m[1][b], m[2][b], m[3][b], m[4][b]};
                o = SBOX[v];
                s[0][b] = o[4]; s[1][b] = o[3]; s[2][b] = o[2]; s[3][b] = o[1]; s[4][b] = o[0];
            end
            m[0] = s[0] ^ rr(s[0], 19) ^ rr(s[0], 28);
            m[1] = s[1] ^ rr(s[1], 61) ^ rr(s[1], 39);
            m[2] = s[2] ^ rr(s[2], 1)  ^ rr(s[2], 6);
            m[3] = s[3] ^ rr(s[3], 10) ^ rr(s[3], 17);
            m[4] = s[4] ^ rr(s[4], 7)  ^ rr(s[4], 41);
        end
    endtask

    task automatic model_load32(input bit use_xor);
        logic [63:0] l;
        for (int k = 0; k < 10; k++) begin
            l = m[k/2];
            if (k % 2 == 1) l[63:32] = use_xor ? (l[63:32] ^ ldw[k]) : ldw[k];
            else            l[31:0]  = use_xor ? (l[31:0]  ^ ldw[k]) : ldw[k];
            m[k/2] = l;
        end
    endtask

    task automatic push_model_a;
        logic [63:0] l;
        for (int k = 0; k < 10; k++) begin
            l = m[k/2];
            qa.push_back((k % 2 == 1) ? l[63:32] : l[31:0]);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle after the accepting edge (T+1).
    task automatic send_cmd(input bit sel, input logic [3:0] r, input logic [1:0] l, input logic u);
        int n;
        cmd_rounds = r; cmd_load = l; cmd_unload = u;
        if (sel) b_cmd_valid = 1'b1; else cmd_valid = 1'b1;
        n = 0;
        while (!(sel ? b_cmd_ready : cmd_ready) && n < 100) begin
            step();
            n++;
        end
        check("cmd_ready_wait", 64'(sel ? b_cmd_ready : cmd_ready), 64'(1));
        step();
        cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
    endtask

    task automatic load_words(input bit sel);
        int n;
        for (int k = 0; k < (sel ? 5 : 10); k++) begin
            if (sel) begin b_din = ldw64[k]; b_din_valid = 1'b1; end
            else     begin din = ldw[k];     din_valid = 1'b1;   end
            n = 0;
            while (!(sel ? b_din_ready : din_ready) && n < 50) begin
                step();
                n++;
            end
            check("din_ready", 64'(sel ? b_din_ready : din_ready), 64'(1));
            step();
        end
        din_valid = 1'b0;
        b_din_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int n;
        n = 0;
        while (!(sel ? b_done : done) && n < 300) begin
            step();
            n++;
        end
        check(tag, 64'(sel ? b_done : done), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int tog, stall, n, seen;
        rst = 1'b1;
        cmd_valid = 0; cmd_rounds = 0; cmd_load = 0; cmd_unload = 0; din = 0; din_valid = 0;
        b_cmd_valid = 0; b_din = 0; b_din_valid = 0; dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) m[i] = '0;
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        step(); step();
        rst = 1'b0;
        #1;
        check("rel_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rel_done", 64'(done), 64'(0));
        check("rel_err", 64'(err), 64'(0));
        check("rel_dout_valid", 64'(dout_valid), 64'(0));
        check("rel_din_ready", 64'(din_ready), 64'(0));
        check("rel_dout", 64'(dout), 64'(0));
        check("rel_b_cmd_ready", 64'(b_cmd_ready), 64'(1));

        // Known-answer permutation of the hash IV, CCW=32 UROL=2.
        for (int k = 0; k < 10; k++) ldw[k] = '0;
        ldw[0] = 32'h00000100;
        ldw[1] = 32'h00400c00;
        for (int i = 0; i < 5; i++) m[i] = KAT[i];
        push_model_a();
        send_cmd(0, 4'd12, 2'd1, 1'b1);
        load_words(0);
        wait_done(0, "t1_done");
        check("t1_q_drained", 64'(qa.size()), 64'(0));
        check("t1_busy_at_done", 64'(busy), 64'(0));

        // Plain 12-round permutation: 6 PERM cycles then done.
        send_cmd(0, 4'd12, 2'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("t2_busy", 64'(busy), 64'(1));
            check("t2_done_early", 64'(done), 64'(0));
            step();
        end
        check("t2_busy_end", 64'(busy), 64'(0));
        check("t2_done", 64'(done), 64'(1));
        step();
        check("t2_done_pulse", 64'(done), 64'(0));
        model_perm(12);
        push_model_a();
        send_cmd(0, 4'd0, 2'd0, 1'b1);
        wait_done(0, "t2_unload_done");

        send_cmd(0, 4'd0, 2'd0, 1'b0);
        check("r0_done", 64'(done), 64'(1));
        check("r0_busy", 64'(busy), 64'(0));
        step();
        check("r0_done_pulse", 64'(done), 64'(0));

        // Illegal commands with stray din_valid; state must stay intact.
        din_valid = 1'b1;
        din = 32'hdeadbeef;
        send_cmd(0, 4'd13, 2'd1, 1'b1);
        check("t3_err_r13", 64'(err), 64'(1));
        check("t3_ready_r13", 64'(cmd_ready), 64'(1));
        check("t3_busy_r13", 64'(busy), 64'(0));
        step();
        check("t3_err_pulse", 64'(err), 64'(0));
        send_cmd(0, 4'd4, 2'd3, 1'b1);
        check("t3_err_load3", 64'(err), 64'(1));
        check("t3_ready_load3", 64'(cmd_ready), 64'(1));
        step();
        send_cmd(0, 4'd5, 2'd0, 1'b1);
        check("t3_err_mod", 64'(err), 64'(1));
        check("t3_ready_mod", 64'(cmd_ready), 64'(1));
        din_valid = 1'b0;
        step();
        push_model_a();
        send_cmd(0, 4'd0, 2'd0, 1'b1);
        wait_done(0, "t3_unload_done");

        // Overwrite with a pattern then XOR the same pattern: all-zero state.
        for (int k = 0; k < 10; k++) ldw[k] = 32'ha5c30f00 + 32'(k * 17);
        send_cmd(0, 4'd0, 2'd1, 1'b0);
        load_words(0);
        wait_done(0, "t4_load_done");
        model_load32(0);
        for (int k = 0; k < 10; k++) qa.push_back(32'h0);
        send_cmd(0, 4'd0, 2'd2, 1'b1);
        load_words(0);
        wait_done(0, "t4_xor_done");
        model_load32(1);

        // Load, 4 rounds, unload under backpressure with a stall on word 4.
        for (int k = 0; k < 10; k++) ldw[k] = 32'h9e3779b9 * 32'(k + 1);
        model_load32(0);
        model_perm(4);
        push_model_a();
        send_cmd(0, 4'd4, 2'd1, 1'b1);
        load_words(0);
        tog = 1; stall = 0; n = 0;
        while (!done && n < 300) begin
            if (dout_valid && beat_a == 4 && stall < 3) begin
                dout_ready = 1'b0;
                stall++;
            end else begin
                dout_ready = (tog != 0);
                tog = 1 - tog;
            end
            step();
            n++;
        end
        dout_ready = 1'b1;
        check("t5_done", 64'(done), 64'(1));
        check("t5_q_drained", 64'(qa.size()), 64'(0));

        // Reset in the third PERM cycle aborts the command.
        send_cmd(0, 4'd12, 2'd0, 1'b0);
        step(); step();
        check("t6_busy_pre", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_cmd_ready", 64'(cmd_ready), 64'(0));
        check("t6_done", 64'(done), 64'(0));
        check("t6_dout", 64'(dout), 64'(0));
        step();
        rst = 1'b0;
        #1;
        check("t6_rel_ready", 64'(cmd_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) seen++;
            step();
        end
        check("t6_no_done", 64'(seen), 64'(0));
        for (int i = 0; i < 5; i++) m[i] = '0;
        push_model_a();
        send_cmd(0, 4'd0, 2'd0, 1'b1);
        wait_done(0, "t6_unload_done");

        // CCW=64, UROL=4 instance.
        ldw64[0] = IV;
        for (int k = 1; k < 5; k++) ldw64[k] = '0;
        for (int i = 0; i < 5; i++) qb.push_back(KAT[i]);
        send_cmd(1, 4'd12, 2'd1, 1'b1);
        load_words(1);
        wait_done(1, "b_kat_done");
        send_cmd(1, 4'd6, 2'd0, 1'b1);
        check("b_err_r6", 64'(b_err), 64'(1));
        check("b_ready_r6", 64'(b_cmd_ready), 64'(1));
        step();
        check("b_err_pulse", 64'(b_err), 64'(0));
        for (int i = 0; i < 5; i++) qb.push_back(KAT[i]);
        send_cmd(1, 4'd0, 2'd0, 1'b1);
        wait_done(1, "b_unload_done");
        send_cmd(1, 4'd8, 2'd0, 1'b0);
        check("b_r8_busy1", 64'(b_busy), 64'(1));
        step();
        check("b_r8_busy2", 64'(b_busy), 64'(1));
        step();
        check("b_r8_done", 64'(b_done), 64'(1));
        check("b_r8_idle", 64'(b_busy), 64'(0));
        for (int i = 0; i < 5; i++) m[i] = KAT[i];
        model_perm(8);
        for (int i = 0; i < 5; i++) qb.push_back(m[i]);
        send_cmd(1, 4'd0, 2'd0, 1'b1);
        wait_done(1, "b_r8_unload_done");

        step();
        check("qa_empty", 64'(qa.size()), 64'(0));
        check("qb_empty", 64'(qb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
